// File: rtl/mini_core_if_fq_pkg.sv
// mini_core_if_fq_pkg
// Shared types and constants for the mini_core instruction-fetch stage.
//   t_fetch_entry : one fetch-queue slot (PC of the request + fetched word)
//   FETCH_PC_STEP : sequential PC increment
//   align_pc()    : clears the low two bits of a redirect target
package mini_core_if_fq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } t_fetch_entry;

  localparam logic [31:0] FETCH_PC_STEP = 32'd4;

  // Instructions are word aligned, so a misaligned target is truncated.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/mini_core_if_fq_buf.sv
// mini_core_if_fq_buf
// Fetch-queue storage: FQ_DEPTH entries of {pc, inst} plus a filled bit per
// entry and three wrap-bit pointers.
//   alloc pointer : next slot reserved for an issued request
//   fill pointer  : next slot to receive an in-order memory response
//   read pointer  : head slot presented to decode
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   alloc_en / alloc_pc      reserve slot at alloc pointer, record its PC
//   fill_en / fill_inst      write instruction at fill pointer, mark filled
//   pop_en                   retire head entry
//   flush_en                 collapse all pointers onto fill pointer, clear filled
//   full                     alloc - read == FQ_DEPTH
//   outstanding              alloc - fill (requests awaiting a response)
//   head_valid / head_entry  head slot contents
module mini_core_if_fq_buf
  import mini_core_if_fq_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_en,
  input  logic [31:0]                  alloc_pc,
  input  logic                         fill_en,
  input  logic [31:0]                  fill_inst,
  input  logic                         pop_en,
  input  logic                         flush_en,
  output logic                         full,
  output logic [$clog2(FQ_DEPTH):0]    outstanding,
  output logic                         head_valid,
  output t_fetch_entry                 head_entry
);

  localparam int unsigned IW = $clog2(FQ_DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]       read_ptr_q, read_ptr_d;
  logic [FQ_DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]       occupancy;
  t_fetch_entry        mem_q [FQ_DEPTH];

  logic [IW-1:0] alloc_idx, fill_idx, read_idx;

  assign alloc_idx = alloc_ptr_q[IW-1:0];
  assign fill_idx  = fill_ptr_q[IW-1:0];
  assign read_idx  = read_ptr_q[IW-1:0];

  // Occupancy counts reserved slots, so in-flight requests already hold space.
  assign occupancy   = alloc_ptr_q - read_ptr_q;
  assign full        = (occupancy == PW'(FQ_DEPTH));
  assign outstanding = alloc_ptr_q - fill_ptr_q;
  assign head_valid  = filled_q[read_idx] && (read_ptr_q != fill_ptr_q);
  assign head_entry  = mem_q[read_idx];

  // Flush wins over everything; otherwise alloc, fill and pop touch distinct
  // slots because alloc needs a non-full queue and fill needs an outstanding
  // request, so their updates can be applied independently.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    read_ptr_d  = read_ptr_q;
    filled_d    = filled_q;
    if (flush_en) begin
      alloc_ptr_d = fill_ptr_q;
      read_ptr_d  = fill_ptr_q;
      filled_d    = '0;
    end else begin
      if (alloc_en) begin
        filled_d[alloc_idx] = 1'b0;
        alloc_ptr_d         = alloc_ptr_q + PW'(1);
      end
      if (fill_en) begin
        filled_d[fill_idx] = 1'b1;
        fill_ptr_d         = fill_ptr_q + PW'(1);
      end
      if (pop_en) begin
        filled_d[read_idx] = 1'b0;
        read_ptr_d         = read_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      read_ptr_q  <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      read_ptr_q  <= read_ptr_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage carries no reset; the filled bits say what is meaningful.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      mem_q[alloc_idx].pc <= alloc_pc;
    end
    if (fill_en) begin
      mem_q[fill_idx].inst <= fill_inst;
    end
  end

endmodule

// File: rtl/mini_core_if_fq.sv
// mini_core_if_fq
// Instruction-fetch stage with a decoupling fetch queue. Generates sequential
// PCs from RESET_PC, issues pipelined requests to instruction memory, queues
// in-order responses with their PCs and hands them to decode. A taken
// redirect reloads the PC, flushes the queue and arranges for the responses
// still in flight to be discarded.
// Ports:
//   Clock, Rst                              clock, asynchronous active-low reset
//   RedirectValidQ102H, RedirectPcQ102H     branch/jump redirect
//   IMemReqValid, IMemReqAddr, IMemReqReady instruction memory request
//   IMemRspValid, IMemRspData               in-order memory response
//   FetchValidQ101H, FetchPcQ101H,
//   FetchInstQ101H, FetchReadyQ101H         head entry to decode
module mini_core_if_fq
  import mini_core_if_fq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        RedirectValidQ102H,
  input  logic [31:0] RedirectPcQ102H,
  output logic        IMemReqValid,
  output logic [31:0] IMemReqAddr,
  input  logic        IMemReqReady,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic        FetchValidQ101H,
  output logic [31:0] FetchPcQ101H,
  output logic [31:0] FetchInstQ101H,
  input  logic        FetchReadyQ101H
);

  localparam int unsigned PW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] drop_cnt_q, drop_cnt_d;

  logic          fq_full;
  logic [PW-1:0] fq_outstanding;
  logic          head_valid;
  t_fetch_entry  head_entry;

  logic          req_accept;
  logic          rsp_drop;
  logic          fill_en;
  logic          pop_en;
  logic [PW-1:0] drop_total;

  // No new request while stale responses are still draining, so the
  // response stream never mixes old and new paths.
  assign IMemReqValid = Rst && !RedirectValidQ102H && !fq_full && (drop_cnt_q == '0);
  assign IMemReqAddr  = pc_q;
  assign req_accept   = IMemReqValid && IMemReqReady;

  assign rsp_drop = IMemRspValid && (drop_cnt_q != '0);
  assign fill_en  = IMemRspValid && (drop_cnt_q == '0) && !RedirectValidQ102H
                    && (fq_outstanding != '0);
  assign pop_en   = head_valid && FetchReadyQ101H && !RedirectValidQ102H;

  // Empty-queue payload is meaningless; drive zero so reset and flushed
  // states read identically.
  assign FetchValidQ101H = head_valid;
  assign FetchPcQ101H    = head_valid ? head_entry.pc : '0;
  assign FetchInstQ101H  = head_valid ? head_entry.inst : '0;

  // Every response still owed by memory after a redirect must be dropped:
  // those already being dropped plus those for queued-but-unfilled slots,
  // less the one arriving right now (it is consumed this cycle either way).
  assign drop_total = drop_cnt_q + fq_outstanding;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (RedirectValidQ102H) begin
      pc_d = align_pc(RedirectPcQ102H);
      if (IMemRspValid && (drop_total != '0)) begin
        drop_cnt_d = drop_total - PW'(1);
      end else begin
        drop_cnt_d = drop_total;
      end
    end else begin
      if (req_accept) begin
        pc_d = pc_q + FETCH_PC_STEP;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - PW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mini_core_if_fq_buf #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_buf (
    .clk         (Clock),
    .rst_n       (Rst),
    .alloc_en    (req_accept),
    .alloc_pc    (pc_q),
    .fill_en     (fill_en),
    .fill_inst   (IMemRspData),
    .pop_en      (pop_en),
    .flush_en    (RedirectValidQ102H),
    .full        (fq_full),
    .outstanding (fq_outstanding),
    .head_valid  (head_valid),
    .head_entry  (head_entry)
  );

endmodule

// File: tb/tb_mini_core_if_fq.sv
// tb_mini_core_if_fq
// Bench for mini_core_if_fq: a main instance (RESET_PC=0x100) driven by a
// queued memory model, and a second instance (RESET_PC=0xFFFF_FFF8) that
// only issues requests, used to watch the PC wrap.
module tb_mini_core_if_fq;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready = 1'b0;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_fetch_valid;
  logic [31:0] w_fetch_pc;
  logic [31:0] w_fetch_inst;

  int total = 0;
  int bad = 0;

  logic        mem_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_pc[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_rd = 0;

  mini_core_if_fq #(
    .RESET_PC (32'h0000_0100),
    .FQ_DEPTH (4)
  ) dut (
    .Clock              (clock),
    .Rst                (rst_n),
    .RedirectValidQ102H (redirect_valid),
    .RedirectPcQ102H    (redirect_pc),
    .IMemReqValid       (req_valid),
    .IMemReqAddr        (req_addr),
    .IMemReqReady       (req_ready),
    .IMemRspValid       (rsp_valid),
    .IMemRspData        (rsp_data),
    .FetchValidQ101H    (fetch_valid),
    .FetchPcQ101H       (fetch_pc),
    .FetchInstQ101H     (fetch_inst),
    .FetchReadyQ101H    (fetch_ready)
  );

  mini_core_if_fq #(
    .RESET_PC (32'hFFFF_FFF8),
    .FQ_DEPTH (4)
  ) dut_wrap (
    .Clock              (clock),
    .Rst                (rst_n),
    .RedirectValidQ102H (1'b0),
    .RedirectPcQ102H    (32'h0),
    .IMemReqValid       (w_req_valid),
    .IMemReqAddr        (w_req_addr),
    .IMemReqReady       (1'b1),
    .IMemRspValid       (1'b0),
    .IMemRspData        (32'h0),
    .FetchValidQ101H    (w_fetch_valid),
    .FetchPcQ101H       (w_fetch_pc),
    .FetchInstQ101H     (w_fetch_inst),
    .FetchReadyQ101H    (1'b0)
  );

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in-order, responds the cycle after accept unless held.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end else begin
      if (rsp_valid && pend.size() > 0) pend.delete(0);
      if (req_valid && req_ready) pend.push_back(req_addr);
      #1;
      if (!mem_hold && pend.size() > 0) begin
        rsp_valid = 1'b1;
        rsp_data  = inst_of(pend[0]);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
    end
  end

  // Records every entry decode actually consumes.
  always @(negedge clock) begin
    if (rst_n && fetch_valid && fetch_ready && !redirect_valid) begin
      got_pc.push_back(fetch_pc);
      got_inst.push_back(fetch_inst);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input logic hold, input logic ready);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b1;
    fetch_ready    = ready;
    mem_hold       = hold;
    exp_pc.delete();
    repeat (2) step();
    got_rd = got_pc.size();
    rst_n  = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] want;
    rst_n = 1'b0;
    mem_hold = 1'b1;
    fetch_ready = 1'b0;
    step();
    total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_valid got=%b want=0", req_valid); end
    total++; if (req_addr !== 32'h100) begin bad++; $display("[TB] FAIL rst_req_addr got=%h want=00000100", req_addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_fetch_valid got=%b want=0", fetch_valid); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_fetch_pc got=%h want=0", fetch_pc); end
    total++; if (fetch_inst !== 32'h0) begin bad++; $display("[TB] FAIL rst_fetch_inst got=%h want=0", fetch_inst); end
    total++; if (w_fetch_pc !== 32'h0 || w_fetch_inst !== 32'h0) begin bad++; $display("[TB] FAIL rst_wrap_fetch got=%h/%h want=0/0", w_fetch_pc, w_fetch_inst); end
    step();
    got_rd = got_pc.size();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      want = 32'h100 + 32'(4 * i);
      total++; if (req_valid !== 1'b1 || req_addr !== want) begin bad++; $display("[TB] FAIL seq_req[%0d] got=%b/%h want=1/%h", i, req_valid, req_addr, want); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_fetch_valid[%0d] got=%b want=0", i, fetch_valid); end
      step();
    end
    total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_req_valid got=%b want=0", req_valid); end
  endtask

  task automatic test_streaming();
    bit found;
    logic [31:0] e;
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) exp_pc.push_back(32'h100 + 32'(4 * i));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (fetch_valid) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL stream_start got=timeout want=fetch_valid"); end
    for (int k = 0; k < 8; k++) begin
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_bubble[%0d] got=%b want=1", k, fetch_valid); end
      step();
    end
    fetch_ready = 1'b0;
    while (got_rd < got_pc.size()) begin
      if (exp_pc.size() == 0) begin
        total++; bad++; $display("[TB] FAIL stream_extra got=%h want=none", got_pc[got_rd]);
      end else begin
        e = exp_pc.pop_front();
        total++; if (got_pc[got_rd] !== e) begin bad++; $display("[TB] FAIL stream_pc got=%h want=%h", got_pc[got_rd], e); end
        total++; if (got_inst[got_rd] !== inst_of(e)) begin bad++; $display("[TB] FAIL stream_inst got=%h want=%h", got_inst[got_rd], inst_of(e)); end
      end
      got_rd++;
    end
    total++; if (exp_pc.size() != 0) begin bad++; $display("[TB] FAIL stream_missing got=%0d left want=0", exp_pc.size()); end
  endtask

  task automatic test_backpressure();
    int cnt;
    logic [31:0] e;
    do_reset(1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (req_valid && req_ready) cnt++;
      step();
    end
    total++; if (cnt != 4) begin bad++; $display("[TB] FAIL bp_accepts got=%0d want=4", cnt); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%b want=0", req_valid); end
    exp_pc.push_back(32'h100);
    fetch_ready = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_pop_cycle got=%b want=0", req_valid); end
    step();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h110) begin bad++; $display("[TB] FAIL bp_resume got=%b/%h want=1/00000110", req_valid, req_addr); end
    fetch_ready = 1'b0;
    while (got_rd < got_pc.size()) begin
      if (exp_pc.size() == 0) begin
        total++; bad++; $display("[TB] FAIL bp_extra got=%h want=none", got_pc[got_rd]);
      end else begin
        e = exp_pc.pop_front();
        total++; if (got_pc[got_rd] !== e) begin bad++; $display("[TB] FAIL bp_pc got=%h want=%h", got_pc[got_rd], e); end
        total++; if (got_inst[got_rd] !== inst_of(e)) begin bad++; $display("[TB] FAIL bp_inst got=%h want=%h", got_inst[got_rd], inst_of(e)); end
      end
      got_rd++;
    end
    total++; if (exp_pc.size() != 0) begin bad++; $display("[TB] FAIL bp_missing got=%0d left want=0", exp_pc.size()); end
  endtask

  task automatic test_redirect();
    int cnt;
    bit found;
    logic [31:0] e;
    do_reset(1'b1, 1'b0);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    mem_hold       = 1'b0;
    step();
    redirect_valid = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_flush got=%b want=0", fetch_valid); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_draining got=%b want=0", req_valid); end
    cnt = 0;
    while (!req_valid && cnt < 10) begin
      step();
      cnt++;
    end
    total++; if (cnt != 2) begin bad++; $display("[TB] FAIL redir_drain_cycles got=%0d want=2", cnt); end
    total++; if (req_addr !== 32'h2000) begin bad++; $display("[TB] FAIL redir_target got=%h want=00002000", req_addr); end
    exp_pc.push_back(32'h2000);
    fetch_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (fetch_valid) found = 1'b1;
      else step();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL redir_fetch got=timeout want=fetch_valid"); end
    step();
    fetch_ready = 1'b0;
    while (got_rd < got_pc.size()) begin
      if (exp_pc.size() == 0) begin
        total++; bad++; $display("[TB] FAIL redir_extra got=%h want=none", got_pc[got_rd]);
      end else begin
        e = exp_pc.pop_front();
        total++; if (got_pc[got_rd] !== e) begin bad++; $display("[TB] FAIL redir_pc got=%h want=%h", got_pc[got_rd], e); end
        total++; if (got_inst[got_rd] !== inst_of(e)) begin bad++; $display("[TB] FAIL redir_inst got=%h want=%h", got_inst[got_rd], inst_of(e)); end
      end
      got_rd++;
    end
    total++; if (exp_pc.size() != 0) begin bad++; $display("[TB] FAIL redir_missing got=%0d left want=0", exp_pc.size()); end
  endtask

  task automatic test_redirect_same_cycle();
    bit found;
    logic [31:0] e;
    do_reset(1'b0, 1'b0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3001;
    step();
    redirect_valid = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL same_spurious got=%b want=0", fetch_valid); end
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h3000) begin bad++; $display("[TB] FAIL same_req got=%b/%h want=1/00003000", req_valid, req_addr); end
    exp_pc.push_back(32'h3000);
    fetch_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (fetch_valid) found = 1'b1;
      else step();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL same_fetch got=timeout want=fetch_valid"); end
    step();
    fetch_ready = 1'b0;
    while (got_rd < got_pc.size()) begin
      if (exp_pc.size() == 0) begin
        total++; bad++; $display("[TB] FAIL same_extra got=%h want=none", got_pc[got_rd]);
      end else begin
        e = exp_pc.pop_front();
        total++; if (got_pc[got_rd] !== e) begin bad++; $display("[TB] FAIL same_pc got=%h want=%h", got_pc[got_rd], e); end
        total++; if (got_inst[got_rd] !== inst_of(e)) begin bad++; $display("[TB] FAIL same_inst got=%h want=%h", got_inst[got_rd], inst_of(e)); end
      end
      got_rd++;
    end
    total++; if (exp_pc.size() != 0) begin bad++; $display("[TB] FAIL same_missing got=%0d left want=0", exp_pc.size()); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    want[3] = 32'h0000_0004;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (w_req_valid !== 1'b1 || w_req_addr !== want[i]) begin bad++; $display("[TB] FAIL wrap_addr[%0d] got=%b/%h want=1/%h", i, w_req_valid, w_req_addr, want[i]); end
      step();
    end
    total++; if (w_req_valid !== 1'b0 || w_fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_full got=%b/%b want=0/0", w_req_valid, w_fetch_valid); end
    mem_hold = 1'b0;
    step();
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100 || fetch_inst !== inst_of(32'h100)) begin bad++; $display("[TB] FAIL midrst_active got=%b/%h/%h want=1/00000100/%h", fetch_valid, fetch_pc, fetch_inst, inst_of(32'h100)); end
    rst_n = 1'b0;
    #1;
    total++; if (req_valid !== 1'b0 || req_addr !== 32'h100) begin bad++; $display("[TB] FAIL midrst_req got=%b/%h want=0/00000100", req_valid, req_addr); end
    total++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0 || fetch_inst !== 32'h0) begin bad++; $display("[TB] FAIL midrst_fetch got=%b/%h/%h want=0/0/0", fetch_valid, fetch_pc, fetch_inst); end
    total++; if (w_req_valid !== 1'b0 || w_req_addr !== 32'hFFFF_FFF8) begin bad++; $display("[TB] FAIL midrst_wrap got=%b/%h want=0/fffffff8", w_req_valid, w_req_addr); end
    step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
